id_stage: RTL and testbench

//  Decode stage feeding the ID/EX register: 32x32 register file, RV32I subset decoder,

---
 rtl/id_stage.sv | 160 ++++++++++++++++
 tb/tb_id_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage: 32-entry register file with write-through bypass, RV32I subset decoder,
// immediate generator and load-use hazard detection feeding the ID/EX register.
module id_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_in,
  input  logic            WB_wen,
  input  logic [4:0]      WB_rd,
  input  logic [XLEN-1:0] WB_data,
  input  logic [4:0]      EX_Rd,
  input  logic            EX_MEM_ren,
  output logic [XLEN-1:0] data_1_out,
  output logic [XLEN-1:0] data_2_out,
  output logic [4:0]      Rd_out,
  output logic [3:0]      ALU_ctrl_out,
  output logic            ALU_src_out,
  output logic [XLEN-1:0] imm_out,
  output logic            MEM_wen_out,
  output logic            MEM_ren_out,
  output logic            REG_wen_out,
  output logic            stall,
  output logic            illegal
);

  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpLui   = 7'b0110111;

  localparam logic [3:0] AluAdd   = 4'h0;
  localparam logic [3:0] AluSub   = 4'h1;
  localparam logic [3:0] AluAnd   = 4'h2;
  localparam logic [3:0] AluOr    = 4'h3;
  localparam logic [3:0] AluXor   = 4'h4;
  localparam logic [3:0] AluSll   = 4'h5;
  localparam logic [3:0] AluSrl   = 4'h6;
  localparam logic [3:0] AluSra   = 4'h7;
  localparam logic [3:0] AluSlt   = 4'h8;
  localparam logic [3:0] AluSltu  = 4'h9;
  localparam logic [3:0] AluPassB = 4'hA;

  logic [XLEN-1:0] regs_q [NREGS];
  logic            illegal_q, illegal_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rdata1, rdata2;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] imm;
  logic            alu_src, mem_wen, mem_ren, reg_wen, rs2_used, legal, kill;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign rs1    = instr_in[19:15];
  assign rs2    = instr_in[24:20];
  assign rd     = instr_in[11:7];

  // alt selects SUB for funct3 000 and SRA for funct3 101
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_map = alt ? AluSub : AluAdd;
      3'b001:  alu_map = AluSll;
      3'b010:  alu_map = AluSlt;
      3'b011:  alu_map = AluSltu;
      3'b100:  alu_map = AluXor;
      3'b101:  alu_map = alt ? AluSra : AluSrl;
      3'b110:  alu_map = AluOr;
      default: alu_map = AluAnd;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (WB_wen && WB_rd != 5'd0) begin
      regs_q[WB_rd] <= WB_data;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rs1 != 5'd0) rdata1 = (WB_wen && WB_rd == rs1) ? WB_data : regs_q[rs1];
    if (rs2 != 5'd0) rdata2 = (WB_wen && WB_rd == rs2) ? WB_data : regs_q[rs2];
  end

  always_comb begin
    alu_op   = AluAdd;
    imm      = '0;
    alu_src  = 1'b0;
    mem_wen  = 1'b0;
    mem_ren  = 1'b0;
    reg_wen  = 1'b0;
    rs2_used = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OpReg: begin
        alu_op   = alu_map(funct3, instr_in[30]);
        reg_wen  = 1'b1;
        rs2_used = 1'b1;
      end
      OpImm: begin
        alu_op  = alu_map(funct3, funct3 == 3'b101 && instr_in[30]);
        alu_src = 1'b1;
        reg_wen = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) imm = XLEN'(instr_in[24:20]);
        else                                     imm = XLEN'($signed(instr_in[31:20]));
      end
      OpLoad: begin
        imm     = XLEN'($signed(instr_in[31:20]));
        alu_src = 1'b1;
        mem_ren = 1'b1;
        reg_wen = 1'b1;
      end
      OpStore: begin
        imm      = XLEN'($signed({instr_in[31:25], instr_in[11:7]}));
        alu_src  = 1'b1;
        mem_wen  = 1'b1;
        rs2_used = 1'b1;
      end
      OpLui: begin
        alu_op  = AluPassB;
        imm     = XLEN'($signed({instr_in[31:12], 12'b0}));
        alu_src = 1'b1;
        reg_wen = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign illegal_d = illegal_q | ~legal;

  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  always_comb begin
    stall = !reset && EX_MEM_ren && EX_Rd != 5'd0 &&
            (EX_Rd == rs1 || (rs2_used && EX_Rd == rs2));
    // Reset, stall and unsupported opcodes all emit the all-zero control word
    kill         = reset || stall || !legal;
    ALU_ctrl_out = kill ? 4'h0 : alu_op;
    ALU_src_out  = !kill && alu_src;
    MEM_wen_out  = !kill && mem_wen;
    MEM_ren_out  = !kill && mem_ren;
    REG_wen_out  = !kill && reg_wen;
    Rd_out       = (!kill && reg_wen) ? rd : 5'd0;
    imm_out      = reset ? '0 : imm;
    data_1_out   = reset ? '0 : rdata1;
    data_2_out   = reset ? '0 : rdata2;
    illegal      = illegal_q;
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, reset corner sequences, then randomized
// stimulus checked against a behavioural model of the decode stage.
module tb_id_stage;

  typedef struct {
    logic [31:0] d1, d2, imm;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        src, mwen, mren, rwen, stl, ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        wbw;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    logic [4:0]  exr;
    logic        exren;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in, WB_data, data_1_out, data_2_out, imm_out;
  logic        WB_wen, EX_MEM_ren, ALU_src_out, MEM_wen_out, MEM_ren_out, REG_wen_out;
  logic        stall, illegal;
  logic [4:0]  WB_rd, EX_Rd, Rd_out;
  logic [3:0]  ALU_ctrl_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic        m_ill;
  vec_t        vecs [21];

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .WB_wen(WB_wen), .WB_rd(WB_rd),
    .WB_data(WB_data), .EX_Rd(EX_Rd), .EX_MEM_ren(EX_MEM_ren), .data_1_out(data_1_out),
    .data_2_out(data_2_out), .Rd_out(Rd_out), .ALU_ctrl_out(ALU_ctrl_out),
    .ALU_src_out(ALU_src_out), .imm_out(imm_out), .MEM_wen_out(MEM_wen_out),
    .MEM_ren_out(MEM_ren_out), .REG_wen_out(REG_wen_out), .stall(stall), .illegal(illegal)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic exp_t mke(input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic [4:0] rd,
                               input logic [3:0] alu, input logic src, input logic mwen,
                               input logic mren, input logic rwen, input logic stl,
                               input logic ill);
    exp_t e;
    e.d1 = d1; e.d2 = d2; e.imm = imm; e.rd = rd; e.alu = alu; e.src = src;
    e.mwen = mwen; e.mren = mren; e.rwen = rwen; e.stl = stl; e.ill = ill;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, input logic wbw, input logic [4:0] wbr,
                               input logic [31:0] wbd, input logic [4:0] exr,
                               input logic exren, input exp_t e);
    vec_t v;
    v.instr = instr; v.wbw = wbw; v.wbr = wbr; v.wbd = wbd; v.exr = exr; v.exren = exren;
    v.e = e;
    return v;
  endfunction

  function automatic logic is_legal(input logic [31:0] ins);
    return ins[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111};
  endfunction

  // Behavioural reference: immediates by arithmetic shifts of the signed word
  function automatic exp_t model(input logic [31:0] ins, input logic rst, input logic wbw,
                                 input logic [4:0] wbr, input logic [31:0] wbd,
                                 input logic [4:0] exr, input logic exren);
    exp_t e;
    logic [4:0] r1, r2;
    logic [2:0] f3;
    logic       use2, stl;
    logic [3:0] base;
    e = mke(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_ill);
    if (rst) return e;
    r1 = ins[19:15]; r2 = ins[24:20]; f3 = ins[14:12];
    e.d1 = (r1 == 0) ? 32'd0 : (wbw && wbr == r1) ? wbd : m_regs[r1];
    e.d2 = (r2 == 0) ? 32'd0 : (wbw && wbr == r2) ? wbd : m_regs[r2];
    case (f3)
      3'd0: base = 4'h0;  3'd1: base = 4'h5;  3'd2: base = 4'h8;  3'd3: base = 4'h9;
      3'd4: base = 4'h4;  3'd5: base = 4'h6;  3'd6: base = 4'h3;  default: base = 4'h2;
    endcase
    use2 = (ins[6:0] == 7'b0110011) || (ins[6:0] == 7'b0100011);
    case (ins[6:0])
      7'b0110011: begin
        e.alu = base + ((ins[30] && (f3 == 0 || f3 == 5)) ? 4'd1 : 4'd0);
        e.rwen = 1; e.rd = ins[11:7];
      end
      7'b0010011: begin
        e.alu = base + ((ins[30] && f3 == 5) ? 4'd1 : 4'd0);
        e.imm = (f3 == 1 || f3 == 5) ? {27'd0, ins[24:20]} : 32'($signed(ins) >>> 20);
        e.src = 1; e.rwen = 1; e.rd = ins[11:7];
      end
      7'b0000011: begin
        e.imm = 32'($signed(ins) >>> 20);
        e.src = 1; e.mren = 1; e.rwen = 1; e.rd = ins[11:7];
      end
      7'b0100011: begin
        e.imm = 32'(($signed(ins) >>> 25) <<< 5) | {27'd0, ins[11:7]};
        e.src = 1; e.mwen = 1;
      end
      7'b0110111: begin
        e.imm = ins & 32'hFFFF_F000;
        e.alu = 4'hA; e.src = 1; e.rwen = 1; e.rd = ins[11:7];
      end
      default: ;
    endcase
    stl = exren && exr != 0 && (exr == r1 || (use2 && exr == r2));
    e.stl = stl;
    if (stl) begin
      e.alu = 0; e.src = 0; e.mwen = 0; e.mren = 0; e.rwen = 0; e.rd = 0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".data1"}, data_1_out, e.d1);
    chk({tag, ".data2"}, data_2_out, e.d2);
    chk({tag, ".imm"}, imm_out, e.imm);
    chk({tag, ".rd"}, {27'd0, Rd_out}, {27'd0, e.rd});
    chk({tag, ".alu"}, {28'd0, ALU_ctrl_out}, {28'd0, e.alu});
    chk({tag, ".ctl"}, {26'd0, ALU_src_out, MEM_wen_out, MEM_ren_out, REG_wen_out, stall,
                        illegal},
        {26'd0, e.src, e.mwen, e.mren, e.rwen, e.stl, e.ill});
  endtask

  task automatic drive(input logic rst, input logic [31:0] ins, input logic wbw,
                       input logic [4:0] wbr, input logic [31:0] wbd, input logic [4:0] exr,
                       input logic exren);
    @(negedge clk);
    reset = rst; instr_in = ins; WB_wen = wbw; WB_rd = wbr; WB_data = wbd;
    EX_Rd = exr; EX_MEM_ren = exren;
    #1;
  endtask

  // Advance one clock and mirror the state update into the model
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_ill = 1'b0;
    end else begin
      if (WB_wen && WB_rd != 0) m_regs[WB_rd] = WB_data;
      if (!is_legal(instr_in)) m_ill = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] ins;
    exp_t        e;
    m_ill = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

    vecs[0]  = mkv(enc_r(0, 0, 3, 0, 4), 1, 3, 32'hDEAD_BEEF, 0, 0,
                   mke(32'hDEAD_BEEF, 0, 0, 4, 0, 0, 0, 0, 1, 0, 0));
    vecs[1]  = mkv(enc_r(0, 0, 3, 0, 4), 0, 0, 0, 0, 0,
                   mke(32'hDEAD_BEEF, 0, 0, 4, 0, 0, 0, 0, 1, 0, 0));
    vecs[2]  = mkv(enc_r(0, 0, 0, 0, 4), 1, 0, 32'h55AA_55AA, 0, 0,
                   mke(0, 0, 0, 4, 0, 0, 0, 0, 1, 0, 0));
    vecs[3]  = mkv(enc_r(0, 0, 0, 0, 4), 0, 0, 0, 0, 0,
                   mke(0, 0, 0, 4, 0, 0, 0, 0, 1, 0, 0));
    vecs[4]  = mkv(enc_i(12'hFFF, 2, 0, 1, 7'b0010011), 0, 0, 0, 0, 0,
                   mke(0, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 1, 0, 0));
    vecs[5]  = mkv(enc_s(12'hFFC, 5, 6), 0, 0, 0, 0, 0,
                   mke(0, 0, 32'hFFFF_FFFC, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs[6]  = mkv({20'h12345, 5'd7, 7'b0110111}, 0, 0, 0, 0, 0,
                   mke(0, 32'hDEAD_BEEF, 32'h1234_5000, 7, 4'hA, 1, 0, 0, 1, 0, 0));
    vecs[7]  = mkv(enc_r(7'h20, 3, 2, 0, 1), 0, 0, 0, 0, 0,
                   mke(0, 32'hDEAD_BEEF, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    vecs[8]  = mkv(enc_r(7'h20, 3, 2, 5, 1), 0, 0, 0, 0, 0,
                   mke(0, 32'hDEAD_BEEF, 0, 1, 7, 0, 0, 0, 1, 0, 0));
    vecs[9]  = mkv(enc_i({7'h20, 5'd3}, 2, 5, 1, 7'b0010011), 0, 0, 0, 0, 0,
                   mke(0, 32'hDEAD_BEEF, 3, 1, 7, 1, 0, 0, 1, 0, 0));
    vecs[10] = mkv(enc_r(0, 3, 2, 3, 1), 0, 0, 0, 0, 0,
                   mke(0, 32'hDEAD_BEEF, 0, 1, 9, 0, 0, 0, 1, 0, 0));
    vecs[11] = mkv(enc_i(12'd16, 9, 2, 8, 7'b0000011), 0, 0, 0, 0, 0,
                   mke(0, 0, 16, 8, 0, 1, 0, 1, 1, 0, 0));
    vecs[12] = mkv(enc_r(0, 1, 5, 0, 6), 0, 0, 0, 5, 1,
                   mke(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs[13] = mkv(enc_r(0, 1, 5, 0, 6), 0, 0, 0, 0, 1,
                   mke(0, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0));
    vecs[14] = mkv(enc_r(0, 1, 5, 0, 6), 0, 0, 0, 5, 0,
                   mke(0, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0));
    vecs[15] = mkv(enc_r(0, 5, 1, 0, 6), 0, 0, 0, 5, 1,
                   mke(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs[16] = mkv(enc_i(12'd5, 0, 0, 6, 7'b0010011), 0, 0, 0, 5, 1,
                   mke(0, 0, 5, 6, 0, 1, 0, 0, 1, 0, 0));
    vecs[17] = mkv(enc_s(12'd0, 5, 6), 0, 0, 0, 5, 1,
                   mke(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs[18] = mkv(32'h0000_007F, 0, 0, 0, 0, 0,
                   mke(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs[19] = mkv(enc_i(12'hFFF, 2, 0, 1, 7'b0010011), 0, 0, 0, 0, 0,
                   mke(0, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 1, 0, 1));
    vecs[20] = mkv(enc_r(0, 0, 3, 0, 4), 0, 0, 0, 0, 0,
                   mke(32'hDEAD_BEEF, 0, 0, 4, 0, 0, 0, 0, 1, 0, 1));

    // Reset held with a would-be stall on the inputs: everything must read zero
    drive(1, enc_r(0, 2, 1, 0, 5), 0, 0, 0, 1, 1);
    tick();
    drive(1, enc_r(0, 2, 1, 0, 5), 1, 1, 32'h1111_1111, 1, 1);
    check_all("reset", mke(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();

    for (int r = 1; r < 32; r += 6) begin
      drive(0, enc_r(0, 5'(r), 5'(r), 0, 5), 0, 0, 0, 0, 0);
      check_all($sformatf("rst_read_x%0d", r), mke(0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0));
      tick();
    end

    for (int i = 0; i < 21; i++) begin
      drive(0, vecs[i].instr, vecs[i].wbw, vecs[i].wbr, vecs[i].wbd, vecs[i].exr,
            vecs[i].exren);
      check_all($sformatf("vec%0d", i), vecs[i].e);
      tick();
    end

    // Reset arriving mid-stall: stall drops in the same cycle
    drive(0, enc_r(0, 1, 3, 0, 6), 0, 0, 0, 3, 1);
    chk("pre_reset_stall", {31'd0, stall}, 32'd1);
    tick();
    drive(1, enc_r(0, 1, 3, 0, 6), 0, 0, 0, 3, 1);
    chk("reset_kills_stall", {31'd0, stall}, 32'd0);
    chk("illegal_before_clear", {31'd0, illegal}, 32'd1);
    tick();
    drive(0, enc_r(0, 0, 3, 0, 4), 0, 0, 0, 0, 0);
    chk("illegal_cleared", {31'd0, illegal}, 32'd0);
    chk("x3_cleared", data_1_out, 32'd0);
    tick();

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: ins = enc_r(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
                             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                             3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        3, 4:    ins = enc_i(12'($urandom), 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)), 7'b0010011);
        5:       ins = enc_i(12'($urandom), 5'($urandom_range(0, 7)), 3'd2,
                             5'($urandom_range(0, 7)), 7'b0000011);
        6:       ins = enc_s(12'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        7:       ins = {20'($urandom), 5'($urandom_range(0, 7)), 7'b0110111};
        8:       ins = $urandom;
        default: ins = enc_r(0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 0,
                             5'($urandom_range(0, 7)));
      endcase
      drive(($urandom_range(0, 39) == 0), ins, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)));
      e = model(instr_in, reset, WB_wen, WB_rd, WB_data, EX_Rd, EX_MEM_ren);
      check_all($sformatf("rnd%0d", n), e);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
